// File: rtl/sw_debounce_pkg.sv
// Shared defaults and width helper for the switch/button debouncer.
// The defaults give a 1 ms sample tick and 20 ms qualification at 100 MHz.
package sw_debounce_pkg;

    localparam int DEF_WIDTH        = 16;
    localparam int DEF_TICK_DIV     = 100000;
    localparam int DEF_STABLE_TICKS = 20;

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchronizer, tick-qualified run counter,
// accepted-level flop and registered single-cycle rise/fall pulses.
module debounce_chan
    import sw_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic             sync1_reg;
    logic             sync_in_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             stable_reg;
    logic             rise_reg;
    logic             fall_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg   <= 1'b0;
            sync_in_reg <= 1'b0;
            cnt_reg     <= '0;
            stable_reg  <= 1'b0;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
        end else begin
            sync1_reg   <= raw;
            sync_in_reg <= sync1_reg;
            rise_reg    <= 1'b0;
            fall_reg    <= 1'b0;
            // Any agreement with the accepted level throws away a partial run.
            if (sync_in_reg == stable_reg) begin
                cnt_reg <= '0;
            end else if (tick) begin
                if (cnt_reg == CNT_LAST) begin
                    stable_reg <= sync_in_reg;
                    rise_reg   <= sync_in_reg;
                    fall_reg   <= ~sync_in_reg;
                    cnt_reg    <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    end

    assign stable = stable_reg;
    assign rise   = rise_reg;
    assign fall   = fall_reg;

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer: one shared sample-tick prescaler feeding
// WIDTH independent debounce channels, all on the undivided board clock.
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_any_change
);

    localparam int PRE_W = cnt_width(TICK_DIV - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_reg;
    logic             tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_reg <= '0;
        end else if (pre_reg == PRE_LAST) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_reg + PRE_W'(1);
        end
    end

    // Tick is a clock enable decoded from the prescaler, never a clock.
    assign tick = (pre_reg == PRE_LAST);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
            debounce_chan #(
                .STABLE_TICKS(STABLE_TICKS)
            ) u_chan (
                .clk    (clk),
                .rst    (rst),
                .tick   (tick),
                .raw    (sw_raw[gi]),
                .stable (sw_stable[gi]),
                .rise   (sw_rise[gi]),
                .fall   (sw_fall[gi])
            );
        end
    endgenerate

    // Built only from registered pulses, so it lines up with them exactly.
    assign sw_any_change = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce (WIDTH=4, TICK_DIV=4, STABLE_TICKS=3):
// hand table for reset, directed corner sequences, and random stimulus vs a model.
module tb_sw_debounce;

    localparam int W  = 4;
    localparam int TD = 4;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw_stable;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         sw_any_change;

    sw_debounce #(
        .WIDTH        (W),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sw_raw        (sw_raw),
        .sw_stable     (sw_stable),
        .sw_rise       (sw_rise),
        .sw_fall       (sw_fall),
        .sw_any_change (sw_any_change)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: raw history two samples deep, tick phase since reset,
    // and per channel the number of consecutive ticks the synced level disagreed.
    logic [W-1:0] m_d1 = '0, m_d2 = '0, m_stable = '0, m_rise = '0, m_fall = '0;
    int           m_phase = 0;
    int           m_runs[W];

    int rise_cnt[W], fall_cnt[W], last_rise[W], last_fall[W];

    typedef struct {
        logic         rst;
        logic [W-1:0] raw;
        logic [W-1:0] stable;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         any;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic model_edge();
        logic tick;
        if (rst) begin
            m_d1 = '0; m_d2 = '0; m_stable = '0; m_rise = '0; m_fall = '0;
            m_phase = 0;
            for (int ch = 0; ch < W; ch++) m_runs[ch] = 0;
        end else begin
            tick    = (m_phase == TD - 1);
            m_phase = (m_phase + 1) % TD;
            m_rise  = '0;
            m_fall  = '0;
            for (int ch = 0; ch < W; ch++) begin
                if (m_d2[ch] == m_stable[ch]) begin
                    m_runs[ch] = 0;
                end else if (tick) begin
                    m_runs[ch]++;
                    if (m_runs[ch] == ST) begin
                        m_stable[ch] = m_d2[ch];
                        m_rise[ch]   = m_d2[ch];
                        m_fall[ch]   = ~m_d2[ch];
                        m_runs[ch]   = 0;
                    end
                end
            end
            m_d2 = m_d1;
            m_d1 = sw_raw;
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("stable", sw_stable, m_stable);
        check("rise", sw_rise, m_rise);
        check("fall", sw_fall, m_fall);
        check("any", {3'b000, sw_any_change}, {3'b000, |(m_rise | m_fall)});
        for (int ch = 0; ch < W; ch++) begin
            if (sw_rise[ch]) begin rise_cnt[ch]++; last_rise[ch] = cyc; end
            if (sw_fall[ch]) begin fall_cnt[ch]++; last_fall[ch] = cyc; end
        end
    endtask

    task automatic hold(input int n);
        repeat (n) step();
    endtask

    task automatic clear_mon();
        for (int ch = 0; ch < W; ch++) begin
            rise_cnt[ch] = 0; fall_cnt[ch] = 0; last_rise[ch] = -1000; last_fall[ch] = -1000;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        for (int ch = 0; ch < W; ch++) m_runs[ch] = 0;
        clear_mon();

        // Reset held 3 cycles with all raw high, then release: first ticks at
        // edges 4, 8, 12 after release, so acceptance shows after edge 12.
        for (int i = 0; i < 16; i++) begin
            tbl[i].rst    = (i < 3);
            tbl[i].raw    = 4'hF;
            tbl[i].stable = (i >= 14) ? 4'hF : 4'h0;
            tbl[i].rise   = (i == 14) ? 4'hF : 4'h0;
            tbl[i].fall   = 4'h0;
            tbl[i].any    = (i == 14);
        end
        for (int i = 0; i < 16; i++) begin
            rst    = tbl[i].rst;
            sw_raw = tbl[i].raw;
            step();
            check("vec_stable", sw_stable, tbl[i].stable);
            check("vec_rise", sw_rise, tbl[i].rise);
            check("vec_fall", sw_fall, tbl[i].fall);
            check("vec_any", {3'b000, sw_any_change}, {3'b000, tbl[i].any});
        end

        // Clean edge on channel 0 from an all-low stable state.
        sw_raw = 4'h0;
        hold(20);
        clear_mon();
        start  = cyc;
        sw_raw = 4'b0001;
        hold(20);
        check_range("clean_rise_count", rise_cnt[0], 1, 1);
        check_range("clean_latency", last_rise[0] - start, 11, 15);
        check("clean_stable", sw_stable, 4'b0001);

        // Bounce on channel 1, then settle high.
        clear_mon();
        for (int k = 0; k < 4; k++) begin
            sw_raw[1] = (k % 2 == 0);
            hold(3);
        end
        check_range("bounce_no_rise", rise_cnt[1], 0, 0);
        start     = cyc;
        sw_raw[1] = 1'b1;
        hold(20);
        check_range("bounce_rise_count", rise_cnt[1], 1, 1);
        check_range("bounce_latency", last_rise[1] - start, 11, 15);

        // Six-cycle glitch on channel 2 must be ignored.
        clear_mon();
        sw_raw[2] = 1'b1;
        hold(6);
        sw_raw[2] = 1'b0;
        hold(20);
        check_range("glitch_rise", rise_cnt[2], 0, 0);
        check_range("glitch_fall", fall_cnt[2], 0, 0);
        check("glitch_stable", sw_stable, 4'b0011);

        // Simultaneous change on all four channels.
        clear_mon();
        sw_raw = 4'b1100;
        hold(20);
        check_range("simul_rise2", rise_cnt[2], 1, 1);
        check_range("simul_rise3", rise_cnt[3], 1, 1);
        check_range("simul_fall0", fall_cnt[0], 1, 1);
        check_range("simul_fall1", fall_cnt[1], 1, 1);
        check_range("simul_same_cycle", last_rise[3] - last_fall[0], 0, 0);
        check_range("simul_same_cycle2", last_rise[2] - last_fall[1], 0, 0);

        // Reset in the middle of qualifying channel 3.
        sw_raw = 4'h0;
        hold(20);
        clear_mon();
        sw_raw[3] = 1'b1;
        hold(8);
        check_range("midrst_no_early", rise_cnt[3], 0, 0);
        rst = 1'b1;
        step();
        rst   = 1'b0;
        start = cyc;
        hold(20);
        check_range("midrst_rise_count", rise_cnt[3], 1, 1);
        check_range("midrst_latency", last_rise[3] - start, 11, 15);

        // Random raw activity with varied hold lengths and occasional reset.
        for (int i = 0; i < 60; i++) begin
            sw_raw = sw_raw ^ 4'($urandom_range(0, 15));
            rst    = ($urandom_range(0, 24) == 0);
            step();
            rst = 1'b0;
            hold($urandom_range(0, 18));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter WIDTH, default 16, number of independent switch/button channels.
REQ-002 Parameter TICK_DIV, default 100000, clk cycles per sample tick (1 ms at 100 MHz); legal range >= 2.
REQ-003 Parameter STABLE_TICKS, default 20, consecutive differing ticks required to accept a new level; legal range >= 1.
REQ-004 clk  input  1  system clock, the same undivided board clock that feeds the CPU clock divider.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sw_raw  input  WIDTH  raw asynchronous switch/button levels.
REQ-007 sw_stable  output  WIDTH  debounced levels; bit 15 drives the divider speed-select input.
REQ-008 sw_rise  output  WIDTH  one-cycle pulse per channel when sw_stable goes 0->1.
REQ-009 sw_fall  output  WIDTH  one-cycle pulse per channel when sw_stable goes 1->0.
REQ-010 sw_any_change  output  1  OR-reduction of sw_rise | sw_fall, same cycle.

Function
REQ-011 Each sw_raw bit SHALL pass through a 2-flop synchronizer (sync_in) before any other logic.
REQ-012 A single shared prescaler SHALL count 0..TICK_DIV-1 and wrap; tick SHALL be high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-013 Per channel, when sync_in equals sw_stable, the channel counter SHALL be forced to 0 on every cycle, tick or not.
REQ-014 When sync_in differs from sw_stable and tick is high, the counter SHALL increment by 1.
REQ-015 On a tick where sync_in differs and counter equals STABLE_TICKS-1, sw_stable SHALL take sync_in on the next clock edge and the counter SHALL return to 0.
REQ-016 Any return of sync_in to the sw_stable value before acceptance (bounce) SHALL clear the counter; partial counts are never retained.
REQ-017 sw_rise/sw_fall SHALL be asserted in the same cycle that sw_stable shows its new value, for exactly one cycle, registered outputs.
REQ-018 Counter width SHALL be clog2(STABLE_TICKS+1); the counter SHALL never exceed STABLE_TICKS-1 and never wrap.
REQ-019 Acceptance latency from a clean sw_raw edge SHALL be between 2+(STABLE_TICKS-1)*TICK_DIV+1 and 2+STABLE_TICKS*TICK_DIV+1 cycles, depending on prescaler phase.
REQ-020 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each produce their own pulse in the same cycle if their acceptance ticks coincide.
REQ-021 Pulses shorter than (STABLE_TICKS-1)*TICK_DIV cycles SHALL never change sw_stable.

Reset
REQ-022 While rst is high at a clk edge: synchronizer flops, prescaler, all channel counters, sw_stable, sw_rise, sw_fall and sw_any_change SHALL become 0.
REQ-023 Reset asserted mid-count SHALL discard all pending acceptance; after release a raw level of 1 SHALL require a full qualification and produce a sw_rise pulse.
REQ-024 First possible tick after reset release SHALL occur TICK_DIV cycles after the first non-reset edge.

Structure
REQ-025 A shared package sw_debounce_pkg SHALL hold default constants (DEF_WIDTH, DEF_TICK_DIV, DEF_STABLE_TICKS) and the clog2 width helper.
REQ-026 One sub-module debounce_chan (synchronizer, counter, stable flop, edge pulses for one bit) SHALL be instantiated WIDTH times by a generate loop; prescaler lives in the top.
REQ-027 No derived or gated clocks; all flops on clk.

Verification (bench with WIDTH=4, TICK_DIV=4, STABLE_TICKS=3)
REQ-028 Reset: hold rst 3 cycles with sw_raw=4'hF -> all outputs 0 during and the cycle after; sw_stable=4'hF and sw_rise=4'hF single pulse within 2+3*4+1=15 cycles of release.
REQ-029 Clean edge: sw_raw[0] 0->1 held -> sw_stable[0]=1 after 11..15 cycles, sw_rise[0] exactly one cycle, sw_any_change coincident.
REQ-030 Bounce: sw_raw[1] toggles 1,0,1,0 every 3 cycles then settles 1 -> no change during toggling; acceptance 11..15 cycles after settling, single sw_rise[1].
REQ-031 Glitch: sw_raw[2] high for 6 cycles then low -> sw_stable[2] stays 0, no pulses.
REQ-032 Simultaneous: sw_raw 4'b0011->4'b1100 at once -> sw_fall=4'b0011 and sw_rise=4'b1100 in the same single cycle.
REQ-033 Reset mid-count: sw_raw[3] rises, rst pulsed 1 cycle after 8 cycles -> no premature acceptance; sw_rise[3] 11..15 cycles after rst release.
